// File: rtl/unidad_mult_div_ex.sv
// -----------------------------------------------------------------------------
// unidad_mult_div_ex
//   EX-stage iterative multiply/divide unit feeding the HI/LO registers.
//   Radix-2 engine, one bit per clock: shift-add for multiply, restoring
//   shift-subtract for divide. Signed operations run on magnitudes and the
//   sign is restored in a final AJUSTE cycle.
//
// Ports
//   clk         clock, rising edge
//   reinicio    asynchronous reset, active low
//   inicio      start request (sampled only when idle)
//   operacion   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   operando_a  multiplicand / dividend
//   operando_b  multiplier / divisor
//   cancelar    pipeline flush, aborts the in-flight operation
//   ocupado     stall request, high while not idle
//   listo       one-cycle pulse, HI/LO just updated
//   hi_salida   product upper half / remainder
//   lo_salida   product lower half / quotient
// -----------------------------------------------------------------------------
module unidad_mult_div_ex #(
    parameter int ANCHO = 32
) (
    input  logic             clk,
    input  logic             reinicio,
    input  logic             inicio,
    input  logic [1:0]       operacion,
    input  logic [ANCHO-1:0] operando_a,
    input  logic [ANCHO-1:0] operando_b,
    input  logic             cancelar,
    output logic             ocupado,
    output logic             listo,
    output logic [ANCHO-1:0] hi_salida,
    output logic [ANCHO-1:0] lo_salida
);
    localparam int CW = $clog2(ANCHO);

    typedef enum logic [1:0] {IDLE, CALC, AJUSTE} estado_t;

    estado_t          estado;
    logic [CW-1:0]    cnt;
    logic             es_div, div_cero, neg_hi, neg_lo;
    logic [ANCHO-1:0] m;       // addend (multiply) or divisor magnitude
    logic [ANCHO-1:0] q;       // multiplier bits / dividend-then-quotient bits
    logic [ANCHO-1:0] a_orig;  // raw dividend, returned in HI on divide by zero
    logic [ANCHO:0]   acc;     // partial product upper half / partial remainder

    // Operand decode at start: magnitudes for signed ops, raw for unsigned
    logic             con_signo, a_neg, b_neg;
    logic [ANCHO-1:0] mag_a, mag_b;

    always_comb begin
        con_signo = ~operacion[0];
        a_neg     = con_signo & operando_a[ANCHO-1];
        b_neg     = con_signo & operando_b[ANCHO-1];
        mag_a     = a_neg ? -operando_a : operando_a;
        mag_b     = b_neg ? -operando_b : operando_b;
    end

    // One iteration of the shared datapath.
    // Divide: acc always holds a remainder < m, so desp < 2m and the sign of
    // desp - m is exactly bit ANCHO of the difference.
    logic [ANCHO:0]   suma, desp, dif, parcial, acc_sig;
    logic [ANCHO-1:0] q_sig;

    always_comb begin
        suma    = acc + {1'b0, m};
        desp    = {acc[ANCHO-1:0], q[ANCHO-1]};
        dif     = desp - {1'b0, m};
        parcial = q[0] ? suma : acc;
        acc_sig = acc;
        q_sig   = q;
        if (es_div) begin
            if (!dif[ANCHO]) begin
                acc_sig = dif;
                q_sig   = {q[ANCHO-2:0], 1'b1};
            end else begin
                acc_sig = desp;
                q_sig   = {q[ANCHO-2:0], 1'b0};
            end
        end else begin
            acc_sig = {1'b0, parcial[ANCHO:1]};
            q_sig   = {parcial[0], q[ANCHO-1:1]};
        end
    end

    // Sign fix-up and special cases, consumed in AJUSTE.
    // 0x8000_0000 / -1 needs no special case: the magnitude quotient is
    // 0x8000_0000 and its two's-complement negation is itself.
    logic [2*ANCHO-1:0] prod;
    logic [ANCHO-1:0]   hi_fin, lo_fin;

    always_comb begin
        prod = {acc[ANCHO-1:0], q};
        if (neg_lo) prod = -prod;
        hi_fin = prod[2*ANCHO-1:ANCHO];
        lo_fin = prod[ANCHO-1:0];
        if (es_div) begin
            if (div_cero) begin
                hi_fin = a_orig;
                lo_fin = '1;
            end else begin
                hi_fin = neg_hi ? -acc[ANCHO-1:0] : acc[ANCHO-1:0];
                lo_fin = neg_lo ? -q : q;
            end
        end
    end

    always_ff @(posedge clk or negedge reinicio) begin
        if (!reinicio) begin
            estado    <= IDLE;
            cnt       <= '0;
            es_div    <= 1'b0;
            div_cero  <= 1'b0;
            neg_hi    <= 1'b0;
            neg_lo    <= 1'b0;
            m         <= '0;
            q         <= '0;
            a_orig    <= '0;
            acc       <= '0;
            ocupado   <= 1'b0;
            listo     <= 1'b0;
            hi_salida <= '0;
            lo_salida <= '0;
        end else begin
            listo <= 1'b0;
            case (estado)
                IDLE: begin
                    // flush wins over a simultaneous start
                    if (inicio && !cancelar) begin
                        es_div   <= operacion[1];
                        div_cero <= operacion[1] && (operando_b == '0);
                        a_orig   <= operando_a;
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= operacion[1] & a_neg;
                        acc      <= '0;
                        q        <= operacion[1] ? mag_a : mag_b;
                        m        <= operacion[1] ? mag_b : mag_a;
                        cnt      <= '0;
                        estado   <= CALC;
                        ocupado  <= 1'b1;
                    end
                end
                CALC: begin
                    if (cancelar) begin
                        estado  <= IDLE;
                        ocupado <= 1'b0;
                    end else begin
                        acc <= acc_sig;
                        q   <= q_sig;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(ANCHO-1)) estado <= AJUSTE;
                    end
                end
                AJUSTE: begin
                    estado  <= IDLE;
                    ocupado <= 1'b0;
                    if (!cancelar) begin
                        hi_salida <= hi_fin;
                        lo_salida <= lo_fin;
                        listo     <= 1'b1;
                    end
                end
                default: begin
                    estado  <= IDLE;
                    ocupado <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_mult_div_ex.sv
module tb_unidad_mult_div_ex;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reinicio = 1'b0;
    logic         inicio = 1'b0;
    logic         cancelar = 1'b0;
    logic [1:0]   operacion = 2'b00;
    logic [W-1:0] a = '0, b = '0;
    logic         ocupado, listo;
    logic [W-1:0] hi, lo;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] last_hi = '0, last_lo = '0;

    always #5 clk = ~clk;

    unidad_mult_div_ex #(.ANCHO(W)) dut (
        .clk(clk), .reinicio(reinicio), .inicio(inicio), .operacion(operacion),
        .operando_a(a), .operando_b(b), .cancelar(cancelar),
        .ocupado(ocupado), .listo(listo), .hi_salida(hi), .lo_salida(lo)
    );

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
    } vec_t;

    // Reference: plain 64-bit arithmetic; returns {hi, lo}
    function automatic logic [63:0] modelo(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, qq, rr;
        logic [63:0] r;
        sx = $signed(x);
        sy = $signed(y);
        case (op)
            2'd0: r = sx * sy;
            2'd1: r = {32'd0, x} * {32'd0, y};
            default: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else if (op == 2'd3) r = {x % y, x / y};
                else begin
                    qq = sx / sy;
                    rr = sx % sy;
                    r = {rr[31:0], qq[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge following the sampling edge E0
    task automatic arranca(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
        operacion = op; a = x; b = y; inicio = 1'b1;
        @(posedge clk);
        @(negedge clk);
        inicio = 1'b0;
    endtask

    // Counts negedges until listo (bounded); k = edges since the start point
    task automatic espera(output int k, output int busy);
        k = 0; busy = 0;
        while (!listo && k < 100) begin
            if (ocupado) busy++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
        int k, busy;
        arranca(op, x, y);
        espera(k, busy);
        chk({nm, "_lat"}, 64'(k), 64'(W + 1));
        chk({nm, "_busy"}, 64'(busy), 64'(W + 1));
        chk({nm, "_ocup_at_listo"}, 64'(ocupado), 64'd0);
        chk({nm, "_hi"}, 64'(hi), 64'(ehi));
        chk({nm, "_lo"}, 64'(lo), 64'(elo));
        last_hi = ehi; last_lo = elo;
        @(negedge clk);
        chk({nm, "_listo_pulse"}, 64'(listo), 64'd0);
    endtask

    vec_t tbl[9];

    initial begin
        int k, busy, nlisto;
        logic [63:0] r;
        logic [1:0]  op;
        logic [31:0] x, y;

        tbl[0] = '{2'd1, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE};
        tbl[1] = '{2'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{2'd3, 32'd100,       32'd7,        32'd2,         32'd14};
        tbl[4] = '{2'd3, 32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF};
        tbl[5] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000};
        tbl[6] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD};
        tbl[7] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0};
        tbl[8] = '{2'd2, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};

        // reset state
        #1;
        chk("rst_outputs", {30'd0, ocupado, listo, hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        reinicio = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo);

        // start ignored while busy; back-to-back start on the listo cycle
        arranca(2'd1, 32'd3, 32'd5);
        repeat (4) @(negedge clk);
        operacion = 2'd1; a = 32'd9; b = 32'd9; inicio = 1'b1;
        @(negedge clk);
        inicio = 1'b0;
        espera(k, busy);
        chk("busy_ign_lat", 64'(k + 5), 64'(W + 1));
        chk("busy_ign_res", {hi, lo}, 64'd15);
        chk("b2b_listo", 64'(listo), 64'd1);
        arranca(2'd1, 32'd6, 32'd7);
        chk("b2b_accepted", 64'(ocupado), 64'd1);
        espera(k, busy);
        chk("b2b_lat", 64'(k), 64'(W + 1));
        chk("b2b_res", {hi, lo}, 64'd42);
        last_hi = 32'd0; last_lo = 32'd42;
        @(negedge clk);

        // cancel mid-divide
        arranca(2'd3, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        cancelar = 1'b1;
        @(negedge clk);
        cancelar = 1'b0;
        chk("cancel_ocupado", 64'(ocupado), 64'd0);
        nlisto = 0;
        for (int i = 0; i < 40; i++) begin
            if (listo) nlisto++;
            @(negedge clk);
        end
        chk("cancel_no_listo", 64'(nlisto), 64'd0);
        chk("cancel_hilo_kept", {hi, lo}, {last_hi, last_lo});

        // cancel beats start in IDLE
        cancelar = 1'b1; operacion = 2'd1; a = 32'd2; b = 32'd2; inicio = 1'b1;
        @(negedge clk);
        cancelar = 1'b0; inicio = 1'b0;
        chk("cancel_idle_nostart", 64'(ocupado), 64'd0);

        // async reset mid-CALC
        arranca(2'd1, 32'd12345, 32'd678);
        repeat (5) @(negedge clk);
        reinicio = 1'b0;
        #1;
        chk("rst_midcalc", {30'd0, ocupado, listo, hi, lo}, 64'd0);
        @(negedge clk);
        reinicio = 1'b1;
        @(negedge clk);
        r = modelo(2'd1, 32'd12345, 32'd678);
        run_op("after_rst", 2'd1, 32'd12345, 32'd678, r[63:32], r[31:0]);

        // randomized against the reference model
        for (int i = 0; i < 30; i++) begin
            op = 2'($urandom_range(0, 3));
            x  = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: y = 32'hFFFF_FFFF;
                2: y = 32'($urandom_range(1, 20));
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) x = 32'h8000_0000;
            r = modelo(op, x, y);
            run_op($sformatf("rnd%0d_op%0d_%h_%h", i, op, x, y), op, x, y, r[63:32], r[31:0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
